// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  // Entries store dest at a fixed width; narrower AW values are zero-extended.
  localparam int unsigned DestW       = 8;
  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic [DestW-1:0] dest;
    logic             is_load;
  } entry_t;

  // Forward select for a bypass from tracked stage `stage`.
  function automatic int unsigned fwd_sel(input int unsigned stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search of one ID source register against the in-flight writers.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0] src_i,
  input  logic          used_i,
  input  entry_t        entries_i [DEPTH],
  output logic          hazard_o,
  output logic [FW-1:0] fwd_o
);

  int thr;

  // Walk oldest to youngest so the youngest match is the last one to assign.
  always_comb begin
    hazard_o = 1'b0;
    fwd_o    = FW'(FWD_REGFILE);
    thr      = 0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (used_i && entries_i[s].valid && (entries_i[s].dest == DestW'(src_i)) &&
          (src_i != '0)) begin
        thr = entries_i[s].is_load ? LOAD_READY : ALU_READY;
        if (s >= thr) begin
          hazard_o = 1'b0;
          fwd_o    = FW'(fwd_sel(unsigned'(s)));
        end else begin
          hazard_o = 1'b1;
          fwd_o    = FW'(FWD_REGFILE);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writers driving ID stalls, flushes and forward selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_reg_write,
  input  logic [AW-1:0] id_dest,
  input  logic          id_is_load,
  input  logic          id_branch_taken,
  input  logic          mem_busy,
  output logic          pc_write_en,
  output logic          ifid_write_en,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          pipe_hold,
  output logic [FW-1:0] fwd_rs,
  output logic [FW-1:0] fwd_rt,
  output logic [31:0]   stall_cycles
);

  if (AW > DestW) begin : g_aw_check
    $error("AW exceeds the stored destination width");
  end

  entry_t      entries_q [DEPTH];
  entry_t      entries_d [DEPTH];
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        hazard_rs, hazard_rt, stall;

  hazard_match #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .FW         (FW)
  ) u_match_rs (
    .src_i     (id_rs),
    .used_i    (id_uses_rs),
    .entries_i (entries_q),
    .hazard_o  (hazard_rs),
    .fwd_o     (fwd_rs)
  );

  hazard_match #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .FW         (FW)
  ) u_match_rt (
    .src_i     (id_rt),
    .used_i    (id_uses_rt),
    .entries_i (entries_q),
    .hazard_o  (hazard_rt),
    .fwd_o     (fwd_rt)
  );

  // A memory freeze dominates: no bubble is inserted while the pipe is held.
  always_comb begin
    stall         = id_valid & (hazard_rs | hazard_rt) & ~mem_busy;
    pc_write_en   = ~(stall | mem_busy);
    ifid_write_en = ~(stall | mem_busy);
    idex_bubble   = stall;
    pipe_hold     = mem_busy;
    ifid_flush    = id_branch_taken & id_valid & ~stall & ~mem_busy;
    stall_cycles  = stall_cycles_q;
  end

  always_comb begin
    entries_d = entries_q;
    if (!mem_busy) begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        entries_d[s] = entries_q[s - 1];
      end
      entries_d[0].valid   = id_valid & id_reg_write & ~stall;
      entries_d[0].dest    = DestW'(id_dest);
      entries_d[0].is_load = id_is_load;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall | mem_busy) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        entries_q[s] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      entries_q      <= entries_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-select unit for the in-order MIPS pipeline. It replaces fixed stall and forward logic with a scoreboard of in-flight writers, DEPTH stages deep.
- Sits beside the ID stage. Drives PC/IFID write enables, the ID/EX bubble, the IF/ID flush and the ID operand forward selects.
- Adds capabilities the fixed design lacks: configurable depth and ready stages, a variable-latency memory freeze, and a saturating stall counter.

Parameters:
- AW, 5: register address width.
- DEPTH, 3: number of tracked stages after ID (stage 0 = EX ... DEPTH-1 = WB).
- ALU_READY, 1: first stage index at which an ALU result is bypassable into ID.
- LOAD_READY, 2: first stage index at which load data is bypassable into ID.
- FW, $clog2(DEPTH+1): forward-select width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source registers.
- id_uses_rs, id_uses_rt  in  1  operand actually read.
- id_reg_write  in  1  ID instruction writes a register.
- id_dest  in  AW  destination register (already RegDst-muxed).
- id_is_load  in  1  ID instruction is a load.
- id_branch_taken  in  1  branch resolved taken in ID.
- mem_busy  in  1  data memory not ready; freeze the whole pipe.
- pc_write_en  out  1  PC update enable.
- ifid_write_en  out  1  IF/ID enable.
- ifid_flush  out  1  load IF/ID with nop.
- idex_bubble  out  1  zero ID/EX controls.
- pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB.
- fwd_rs, fwd_rt  out  FW  0 = regfile, k = stage k-1.
- stall_cycles  out  32  saturating count of lost cycles.

Behaviour:
- Reset is the only asynchronous-free clear. At reset all entries are invalid and stall_cycles = 0. The first cycle after reset gives pc_write_en = 1, ifid_write_en = 1, flush = 0, bubble = 0, hold = 0, fwd = 0.
- State: DEPTH entries {valid, dest, is_load}. Entry 0 is the EX instruction.
- A source matches an entry when the source is used, the entry is valid, the entry dest equals the source, and the dest is not 0. Register 0 never matches.
- Priority: the youngest match (lowest stage index) decides. An older match is never used while a younger one exists.
- ready(s) = s >= (is_load ? LOAD_READY : ALU_READY).
- If the youngest match is ready, fwd = s+1. If it is not ready, raise a hazard and set fwd = 0. If there is no match, fwd = 0. A match in the WB stage still forwards; regfile write-first is not relied on.
- stall = id_valid & hazard(rs | rt) & ~mem_busy.
- Stall outputs: pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1.
- mem_busy outputs: pc_write_en = 0, ifid_write_en = 0, pipe_hold = 1, idex_bubble = 0, ifid_flush = 0. Scoreboard entries hold unchanged. mem_busy dominates stall.
- ifid_flush = id_branch_taken & id_valid & ~stall & ~mem_busy. A taken branch is never acted on while stalled.
- Advance (every cycle without mem_busy):
  - Entries shift: entry[s+1] <= entry[s]. The entry leaving WB retires.
  - entry[0] <= {id_valid & id_reg_write & ~stall, id_dest, id_is_load}. A bubble inserts valid = 0.
- Outputs are combinational from the current entries and ID inputs, so there is zero-cycle latency into same-cycle enables. The scoreboard update takes effect at the next edge.
- stall_cycles increments by 1 on each cycle with stall | mem_busy and saturates at 0xFFFFFFFF. It does not wrap.
- Reset asserted mid-stall or mid-freeze clears everything at the edge. The next cycle has no hazards.

Decomposition:
- hazard_pkg holds:
  - FWD_REGFILE = 0;
  - the entry struct {valid, dest, is_load};
  - the function fwd_sel(stage) = stage+1.
- One sub-module, hazard_match. It is instantiated twice (rs, rt) and does a combinational priority search over the entries, returning {hazard, fwd}.
- Entry storage, the shift logic and the counter stay in the top module.

Test Plan:
- ALU producer $5 enters EX; next ID reads rs = $5 → that cycle: stall = 0 (ALU_READY = 1, producer in EX) is false. Required: stall 1 cycle, then fwd_rs = 2 (MEM), then the pipe proceeds; stall_cycles = 1.
- Load into $8 followed immediately by use of $8 → 2 stall cycles (bubbles), then fwd_rt = 3 (WB); pc_write_en low for exactly 2 cycles.
- Two writers to $3 in MEM (ALU) and WB (load); ID reads $3 → fwd_rs = 2 (youngest wins), no stall.
- Writer to $0 in EX; ID uses $0 → fwd = 0, no stall.
- mem_busy high for 4 cycles during a load-use stall → pipe_hold = 1, idex_bubble = 0 for 4 cycles, entries frozen. The stall resumes after release; stall_cycles counts all cycles.
- Taken branch with no hazard → ifid_flush = 1 for one cycle. The same branch with a pending EX writer of rs → flush stays 0 until the stall clears. Reset during a stall → all outputs return to the reset values next cycle.
